// File: rtl/mvm_stream.sv
// Streaming signed matrix-vector multiplier y = A*x with P lockstep MAC lanes.
// A and x are loaded word-serially; results drain in row order over a valid/ready port.
module mvm_stream #(
    parameter int M   = 8,
    parameter int N   = 8,
    parameter int B   = 8,
    parameter int P   = 2,
    parameter int SAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_matrix,
    input  logic             load_vector,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*B-1:0]   out_data,
    output logic             busy,
    output logic             done
);

    localparam int unsigned OW = 2 * B;
    localparam int unsigned W  = 2 * B + $clog2(N);
    localparam int unsigned NP = M / P;
    localparam int unsigned K  = NP * N;
    localparam int unsigned AW = $clog2(M * N);
    localparam int unsigned XW = $clog2(N);
    localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int unsigned CW = $clog2(K + 2);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_A  = 3'd1;
    localparam logic [2:0] ST_LOAD_X  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam logic signed [W-1:0] SMAX = {{(W - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    logic [2:0]          state_q, state_d;
    logic [AW-1:0]       ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XW-1:0]       col_q, col_d;
    logic [PW-1:0]       pass_q, pass_d;
    logic                pv_q, pv_d;
    logic                pfirst_q, pfirst_d;
    logic                plast_q, plast_d;
    logic [PW-1:0]       ppass_q, ppass_d;
    logic [RW-1:0]       ridx_q, ridx_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [OW-1:0]       out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic signed [OW-1:0] prod_q [P];
    logic signed [OW-1:0] prod_d [P];
    logic signed [W-1:0]  acc_q  [P];
    logic signed [W-1:0]  acc_d  [P];

    logic [B-1:0]         a_mem_q [M*N];
    logic [B-1:0]         x_mem_q [N];
    logic signed [W-1:0]  res_q   [M];

    logic                 a_we, x_we;
    logic                 res_we    [P];
    logic [RW-1:0]        res_widx  [P];
    logic signed [W-1:0]  res_wdata [P];

    // Final row value: wrap to the low 2B bits or clamp to the signed 2B range.
    function automatic logic [OW-1:0] fmt(input logic signed [W-1:0] v);
        if (SAT != 0) begin
            if (v > SMAX) return SMAX[OW-1:0];
            if (v < SMIN) return SMIN[OW-1:0];
        end
        return v[OW-1:0];
    endfunction

    function automatic logic [AW-1:0] a_addr(input int unsigned lane,
                                             input logic [PW-1:0] pass,
                                             input logic [XW-1:0] col);
        return AW'((lane + P * pass) * N + col);
    endfunction

    // Lane datapath: registered product, then accumulate; row completes into res_q.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            prod_d[l]    = OW'(signed'(a_mem_q[a_addr(l, pass_q, col_q)]))
                         * OW'(signed'(x_mem_q[col_q]));
            res_wdata[l] = (pfirst_q ? W'(0) : acc_q[l]) + W'(prod_q[l]);
            acc_d[l]     = pv_q ? res_wdata[l] : acc_q[l];
            res_we[l]    = pv_q & plast_q;
            res_widx[l]  = RW'(l + P * ppass_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        pass_d      = pass_q;
        pv_d        = 1'b0;
        pfirst_d    = 1'b0;
        plast_d     = 1'b0;
        ppass_d     = ppass_q;
        ridx_d      = ridx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        a_we        = 1'b0;
        x_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_matrix) begin
                    state_d  = ST_LOAD_A;
                    ld_cnt_d = '0;
                end else if (load_vector) begin
                    state_d  = ST_LOAD_X;
                    ld_cnt_d = '0;
                end else if (start) begin
                    state_d = ST_COMPUTE;
                    cnt_d   = '0;
                    col_d   = '0;
                    pass_d  = '0;
                end
            end
            ST_LOAD_A: begin
                if (in_valid) begin
                    a_we = 1'b1;
                    if (ld_cnt_q == AW'(M * N - 1)) begin
                        state_d  = ST_IDLE;
                        ld_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + AW'(1);
                    end
                end
            end
            ST_LOAD_X: begin
                if (in_valid) begin
                    x_we = 1'b1;
                    if (ld_cnt_q == AW'(N - 1)) begin
                        state_d  = ST_IDLE;
                        ld_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + AW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q < CW'(K)) begin
                    pv_d     = 1'b1;
                    pfirst_d = (col_q == '0);
                    plast_d  = (col_q == XW'(N - 1));
                    ppass_d  = pass_q;
                    if (col_q == XW'(N - 1)) begin
                        col_d  = '0;
                        pass_d = pass_q + PW'(1);
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
                // Two extra cycles flush the product register and the last accumulate.
                if (cnt_q == CW'(K + 1)) begin
                    state_d     = ST_DRAIN;
                    ridx_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = fmt(res_q[0]);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (ridx_q == RW'(M - 1)) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        ridx_d     = ridx_q + RW'(1);
                        out_data_d = fmt(res_q[ridx_q + RW'(1)]);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_X);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ld_cnt_q    <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            pass_q      <= '0;
            pv_q        <= 1'b0;
            pfirst_q    <= 1'b0;
            plast_q     <= 1'b0;
            ppass_q     <= '0;
            ridx_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int l = 0; l < P; l++) begin
                prod_q[l] <= '0;
                acc_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            pass_q      <= pass_d;
            pv_q        <= pv_d;
            pfirst_q    <= pfirst_d;
            plast_q     <= plast_d;
            ppass_q     <= ppass_d;
            ridx_q      <= ridx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int l = 0; l < P; l++) begin
                prod_q[l] <= prod_d[l];
                acc_q[l]  <= acc_d[l];
            end
        end
    end

    // Operand and result storage is deliberately unreset; writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (a_we) a_mem_q[ld_cnt_q] <= in_data;
            if (x_we) x_mem_q[XW'(ld_cnt_q)] <= in_data;
            for (int l = 0; l < P; l++) begin
                if (res_we[l]) res_q[res_widx[l]] <= res_wdata[l];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mvm_stream.sv
// Directed bench for mvm_stream (M=N=4, P=2): a wrapping and a saturating instance share stimulus.
module tb_mvm_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0;

    logic        in_ready_w, out_valid_w, busy_w, done_w;
    logic [15:0] out_data_w;
    logic        in_ready_s, out_valid_s, busy_s, done_s;
    logic [15:0] out_data_s;

    int n_cmp = 0;
    int n_err = 0;

    mvm_stream #(.M(4), .N(4), .B(8), .P(2), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
        .start(start), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .busy(busy_w), .done(done_w)
    );

    mvm_stream #(.M(4), .N(4), .B(8), .P(2), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
        .start(start), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .busy(busy_s), .done(done_s)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready_w),  0);
        chk({tag, "_out_valid"}, 32'(out_valid_w), 0);
        chk({tag, "_out_data"},  32'(out_data_w),  0);
        chk({tag, "_busy"},      32'(busy_w),      0);
        chk({tag, "_done"},      32'(done_w),      0);
        chk({tag, "_sat_busy"},  32'(busy_s),      0);
    endtask

    // Issue a load command, stream n words (optionally with in_valid gaps), check the exit.
    task automatic load(input bit is_a, input bit also_start, input int n,
                        input logic signed [7:0] w [16], input bit gaps);
        @(negedge clk);
        load_matrix = is_a;
        load_vector = ~is_a;
        start       = also_start;
        @(negedge clk);
        load_matrix = 1'b0;
        load_vector = 1'b0;
        start       = 1'b0;
        chk("load_in_ready_up", 32'(in_ready_w), 1);
        chk("load_busy_up", 32'(busy_w), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && i[0]) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            @(negedge clk);
            if (is_a && i == 3) chk("loadA_busy_after_4", 32'(busy_w), 1);
        end
        in_valid = 1'b0;
        chk("load_in_ready_down", 32'(in_ready_w), 0);
        chk("load_busy_down", 32'(busy_w), 0);
    endtask

    // Start, measure latency, drain with optional stall/pokes; stop_after>=0 returns mid-drain.
    task automatic run(input logic signed [31:0] ew [4], input logic signed [31:0] es [4],
                       input int stall_row, input bit poke, input int stop_after);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("run_busy", 32'(busy_w), 1);
        while (!out_valid_w && n < 40) begin
            if (poke) begin
                start       = n[0];
                load_vector = ~n[0];
            end
            @(negedge clk);
            start       = 1'b0;
            load_vector = 1'b0;
            n++;
        end
        chk("latency", n, 11);
        for (int r = 0; r < 4; r++) begin
            if (r == stop_after) return;
            chk($sformatf("valid_r%0d", r), 32'(out_valid_w), 1);
            chk($sformatf("wrap_r%0d", r), 32'($signed(out_data_w)), ew[r]);
            chk($sformatf("sat_r%0d", r), 32'($signed(out_data_s)), es[r]);
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid_w), 1);
                    chk("stall_data", 32'($signed(out_data_w)), ew[r]);
                end
                out_ready = 1'b1;
            end
            if (poke && r < 3) begin
                start       = 1'b1;
                load_vector = 1'b1;
            end
            @(negedge clk);
            start       = 1'b0;
            load_vector = 1'b0;
        end
        chk("done_pulse", 32'(done_w), 1);
        chk("done_sat", 32'(done_s), 1);
        chk("done_busy", 32'(busy_w), 0);
        chk("done_valid", 32'(out_valid_w), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_w), 0);
    endtask

    logic signed [7:0]  am [16];
    logic signed [7:0]  xv [16];
    logic signed [31:0] ew [4];
    logic signed [31:0] es [4];

    initial begin
        repeat (2) @(negedge clk);
        check_idle("reset0");
        reset = 1'b0;

        // Identity
        am = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
        xv = '{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load(1'b1, 1'b0, 16, am, 1'b0);
        load(1'b0, 1'b0, 4, xv, 1'b0);
        ew = '{1, 2, 3, 4};
        run(ew, ew, -1, 1'b0, -1);

        // Saturation: every row sums to 65536
        am = '{default: -8'sd128};
        xv = '{default: -8'sd128};
        load(1'b1, 1'b0, 16, am, 1'b0);
        load(1'b0, 1'b0, 4, xv, 1'b0);
        ew = '{0, 0, 0, 0};
        es = '{32767, 32767, 32767, 32767};
        run(ew, es, -1, 1'b0, -1);

        // Load gaps and output backpressure on row 1
        am = '{1,2,3,4, -1,0,1,2, 5,5,5,5, 0,0,0,-7};
        xv = '{1,-1,2,3, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load(1'b1, 1'b0, 16, am, 1'b1);
        load(1'b0, 1'b0, 4, xv, 1'b1);
        ew = '{17, 7, 25, -21};
        run(ew, ew, 1, 1'b0, -1);

        // Commands during COMPUTE/DRAIN are ignored
        run(ew, ew, -1, 1'b1, -1);

        // Reset in LOAD_A after 7 words
        am = '{127,127,127,127, -128,127,0,0, 2,-3,4,-5, 10,20,30,40};
        xv = '{127,127,1,-1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        @(negedge clk);
        load_matrix = 1'b1;
        @(negedge clk);
        load_matrix = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(-i - 50);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_idle("reset_loadA");
        reset = 1'b0;

        // Reset during DRAIN after 2 rows, then a fresh full load
        load(1'b1, 1'b0, 16, am, 1'b0);
        load(1'b0, 1'b0, 4, xv, 1'b0);
        ew = '{32258, -127, -118, 3800};
        run(ew, ew, -1, 1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_drain");
        reset = 1'b0;
        load(1'b1, 1'b0, 16, am, 1'b0);
        load(1'b0, 1'b0, 4, xv, 1'b0);
        run(ew, ew, -1, 1'b0, -1);

        // load_matrix beats start; then reuse A with a new x
        am = '{default: -8'sd128};
        xv = '{default: 8'sd127};
        load(1'b1, 1'b1, 16, am, 1'b0);
        load(1'b0, 1'b0, 4, xv, 1'b0);
        ew = '{512, 512, 512, 512};
        es = '{-32768, -32768, -32768, -32768};
        run(ew, es, -1, 1'b0, -1);
        xv = '{1,2,-3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load(1'b0, 1'b0, 4, xv, 1'b0);
        ew = '{-512, -512, -512, -512};
        run(ew, ew, -1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_stream.md
# mvm_stream

Parametrised matrix-vector multiply engine computing y = A·x for a signed M×N matrix A and an N-vector x, using P parallel MAC lanes. It is the successor to the fixed 20×20 single-lane unit. It adds non-square shapes, a configurable lane count, a selectable saturating or wrapping output, and valid/ready streaming handshakes on both input and output with full backpressure. It sits between the host word stream and downstream result consumers.

## Interface
- M, 8, matrix rows; M % P == 0
- N, 8, matrix columns / vector length; N ≥ 2
- B, 8, signed input word width
- P, 2, MAC lanes; 1 ≤ P ≤ M
- SAT, 0, output mode: 0 = wrap (low 2B bits), 1 = saturate to signed 2B range
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- load_matrix  in  1  command: load A, row-major, M·N words
- load_vector  in  1  command: load x, N words
- start  in  1  command: compute y
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- in_data  in  B  signed input word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  2B  signed result y[r]
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after last result accepted

## Operation
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN.
- Commands are sampled only in IDLE and ignored in all other states.
- Priority when several commands are high in the same cycle: load_matrix > load_vector > start.
- LOAD_A / LOAD_X: in_ready = 1. A word transfers when in_valid & in_ready. An internal counter advances only on a transfer. After the final word (M·N for A, N for x) the block returns to IDLE.
- COMPUTE:
  - Lane l owns rows l, l+P, l+2P, …
  - Each lane runs M/P passes of N cycles, one MAC per cycle.
  - The multiplier output is registered (1 stage) before accumulation.
  - Accumulators are W = 2B + clog2(N) bits, so no internal overflow occurs.
  - Completed rows go into an M-entry result buffer.
- DRAIN: rows are emitted in order y[0]..y[M-1] through the out handshake. After the final transfer the block returns to IDLE with done pulsed.
- Output width rule:
  - SAT=0: out_data = acc[2B-1:0].
  - SAT=1: clamp to [−2^(2B−1), 2^(2B−1)−1].
- A and x storage is not reset. It persists across computations and across reset. start without a prior load yields unspecified data but exact timing.
- Reset in any state:
  - Next cycle is IDLE.
  - All load counters and pass counters are cleared.
  - The result buffer is invalidated.
  - Any partial load is abandoned.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- A command sampled at cycle t gives busy=1 from t+1. For loads, in_ready=1 from t+1.
- in_ready drops in the cycle after the final load transfer; busy drops in the same cycle.
- Compute latency: first out_valid at cycle t + (M/P)·N + 3 after start is sampled at t.
- out_data and out_valid hold stable while out_valid & !out_ready. The next row is presented in the cycle after a transfer; no bubbles occur when out_ready is held high.
- done=1 for exactly one cycle, in the cycle after the M-th output transfer. busy=0 in that same cycle.
- in_valid gaps stall the load counter without error. in_valid outside LOAD states is ignored.

## Test plan
- Identity check. Config: M=N=4, P=2, SAT=0. Stimulus: load A=I, x=[1,2,3,4], start. Required response: outputs 1,2,3,4; first out_valid exactly 11 cycles after start; done 1 cycle after the 4th transfer.
- Saturation. Config: M=N=4, P=2, all A=−128, x=−128 (row sum 65536). Required response: SAT=1 gives 32767 ×4; SAT=0 gives 0 ×4.
- Backpressure and load gaps. Stimulus: toggle in_valid every other cycle during loads; hold out_ready=0 for 5 cycles on row 1. Required response: all M·N words captured; out_data for row 1 stable throughout the stall; no row lost or duplicated.
- Ignored commands. Stimulus: assert start and load_vector during COMPUTE and DRAIN. Required response: no state change; results unchanged.
- Reset mid-operation. Stimulus: reset in LOAD_A after 7 words, then again during DRAIN after 2 rows. Required response: next cycle IDLE with all outputs at reset values; a fresh full load and start produce correct y.
- Priority and reuse. Stimulus: assert load_matrix and start together in IDLE. Required response: enters LOAD_A. Then reload only x and start again. Required response: y is computed with the retained A.
